// File: rtl/tx_frame_sched.sv
// Frame scheduler: round-robin grant among requesters, then sequences header, payload and pad
// beats of one frame on AXI-Stream, followed by an inter-frame gap.
module tx_frame_sched #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned HDR_LEN    = 14,
  parameter int unsigned MIN_LEN    = 46,
  parameter int unsigned MAX_LEN    = 1500,
  parameter int unsigned IFG_CYCLES = 12,
  localparam int unsigned IdW       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*16-1:0] req_len,
  output logic [NUM_REQ-1:0]    grant,
  output logic [IdW-1:0]        active_id,
  output logic                  busy,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tlast,
  output logic [15:0]           byte_idx,
  output logic                  hdr_phase,
  output logic                  data_phase,
  output logic                  pad_phase,
  output logic                  frame_done,
  output logic                  len_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (HDR_LEN == 0) begin : g_bad_hdr_len
    $error("HDR_LEN must be at least 1");
  end
  if (HDR_LEN + MAX_LEN >= 65536) begin : g_bad_max_len
    $error("HDR_LEN + MAX_LEN must fit in 16 bits");
  end

  localparam logic [15:0] HdrLen = 16'(HDR_LEN);
  localparam logic [15:0] MinLen = 16'(MIN_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StGap} state_e;

  state_e         state_q;
  logic [IdW-1:0] rr_ptr_q;
  logic [15:0]    data_end_q;  // first pad index, HDR_LEN + L
  logic [15:0]    last_idx_q;  // tlast index, HDR_LEN + E - 1
  logic [15:0]    gap_cnt_q;

  logic [15:0]    len_arr [NUM_REQ];
  logic           found;
  logic [IdW-1:0] win;
  logic [IdW-1:0] win_next;
  logic [NUM_REQ-1:0] win_oh;
  logic [15:0]    win_len;
  logic [15:0]    eff_len;
  logic [15:0]    nidx;
  int unsigned    cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
    assign len_arr[g] = req_len[g*16 +: 16];
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand[IdW-1:0]]) begin
        found = 1'b1;
        win   = cand[IdW-1:0];
      end
    end
    win_oh      = '0;
    win_oh[win] = found;
    win_next    = (32'(win) == NUM_REQ - 1) ? '0 : win + IdW'(1);
    win_len     = len_arr[win];
    eff_len     = (win_len < MinLen) ? MinLen : win_len;
    nidx        = byte_idx + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      data_end_q <= '0;
      last_idx_q <= '0;
      gap_cnt_q  <= '0;
      grant      <= '0;
      active_id  <= '0;
      busy       <= 1'b0;
      tvalid     <= 1'b0;
      tlast      <= 1'b0;
      byte_idx   <= '0;
      hdr_phase  <= 1'b0;
      data_phase <= 1'b0;
      pad_phase  <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      grant      <= '0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant    <= win_oh;
            rr_ptr_q <= win_next;
            if (win_len == 16'd0 || win_len > MaxLen) begin
              len_err <= 1'b1;
            end else begin
              active_id  <= win;
              data_end_q <= HdrLen + win_len;
              last_idx_q <= HdrLen + eff_len - 16'd1;
              state_q    <= StHdr;
              busy       <= 1'b1;
              tvalid     <= 1'b1;
              byte_idx   <= '0;
              hdr_phase  <= 1'b1;
              data_phase <= 1'b0;
              pad_phase  <= 1'b0;
              tlast      <= 1'b0;
            end
          end
        end
        StHdr, StData: begin
          if (tready) begin
            if (tlast) begin
              frame_done <= 1'b1;
              tvalid     <= 1'b0;
              tlast      <= 1'b0;
              byte_idx   <= '0;
              hdr_phase  <= 1'b0;
              data_phase <= 1'b0;
              pad_phase  <= 1'b0;
              if (IFG_CYCLES == 0) begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end else begin
                state_q   <= StGap;
                gap_cnt_q <= 16'(IFG_CYCLES - 1);
              end
            end else begin
              // Flags are registered, so they are derived from the index of the next beat.
              byte_idx   <= nidx;
              hdr_phase  <= nidx < HdrLen;
              data_phase <= (nidx >= HdrLen) && (nidx < data_end_q);
              pad_phase  <= nidx >= data_end_q;
              tlast      <= nidx == last_idx_q;
              if (state_q == StHdr && nidx == HdrLen) state_q <= StData;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == 16'd0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Bench for tx_frame_sched: transaction-level reference model checking arbitration, beat
// sequencing, backpressure, gaps, length rejection and reset, plus a 3-requester zero-gap instance.
module tb_tx_frame_sched;

  localparam int NREQ = 2;
  localparam int HDR  = 14;
  localparam int MINL = 46;
  localparam int MAXL = 1500;
  localparam int IFG  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] req_len = '0;
  logic        tready = 1'b1;
  logic [1:0]  grant;
  logic        active_id, busy, tvalid, tlast, hdr_phase, data_phase, pad_phase;
  logic        frame_done, len_err;
  logic [15:0] byte_idx;

  logic [2:0]  z_req = '0;
  logic [47:0] z_len = {16'd6, 16'd3, 16'd5};
  logic [2:0]  z_grant;
  logic [1:0]  z_id;
  logic        z_busy, z_tvalid, z_tlast, z_hdr, z_data, z_pad, z_done, z_err;
  logic [15:0] z_idx;

  always #5 clk = ~clk;

  tx_frame_sched #(
    .NUM_REQ(NREQ), .HDR_LEN(HDR), .MIN_LEN(MINL), .MAX_LEN(MAXL), .IFG_CYCLES(IFG)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .grant(grant), .active_id(active_id),
    .busy(busy), .tvalid(tvalid), .tready(tready), .tlast(tlast), .byte_idx(byte_idx),
    .hdr_phase(hdr_phase), .data_phase(data_phase), .pad_phase(pad_phase),
    .frame_done(frame_done), .len_err(len_err)
  );

  tx_frame_sched #(
    .NUM_REQ(3), .HDR_LEN(2), .MIN_LEN(4), .MAX_LEN(100), .IFG_CYCLES(0)
  ) dut_z (
    .clk(clk), .rst(rst), .req(z_req), .req_len(z_len), .grant(z_grant), .active_id(z_id),
    .busy(z_busy), .tvalid(z_tvalid), .tready(1'b1), .tlast(z_tlast), .byte_idx(z_idx),
    .hdr_phase(z_hdr), .data_phase(z_data), .pad_phase(z_pad),
    .frame_done(z_done), .len_err(z_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int m_rr   = 0;
  int cur_len;
  int won;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int arb_pick(input logic [1:0] r);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(m_rr + i) % NREQ]) return (m_rr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] idle_vec();
    return 64'({grant, active_id, busy, tvalid, tlast, byte_idx, hdr_phase, data_phase,
                pad_phase, frame_done, len_err});
  endfunction

  // Present a request pattern for one arbitration and check the grant cycle.
  task automatic try_arb(input logic [1:0] r, input logic [15:0] l0, input logic [15:0] l1);
    int w;
    int lw;
    logic bad;
    req = r;
    req_len = {l1, l0};
    tick();
    w = arb_pick(r);
    won = 0;
    if (w < 0) begin
      check_eq("no_req_grant", 64'({grant, len_err, tvalid, busy}), 64'(0));
      return;
    end
    lw  = (w == 1) ? int'(l1) : int'(l0);
    bad = (lw == 0) || (lw > MAXL);
    m_rr = (w + 1) % NREQ;
    check_eq("grant", 64'(grant), 64'(1 << w));
    check_eq("len_err", 64'(len_err), 64'(bad));
    check_eq("start_valid", 64'({tvalid, busy}), bad ? 64'(0) : 64'(3));
    if (!bad) begin
      check_eq("active_id", 64'(active_id), 64'(w));
      cur_len = lw;
      won = 1;
    end
  endtask

  task automatic run_frame(input int len, input bit bp, input int abort_at);
    int e;
    int total;
    int k;
    bit tr;
    logic [20:0] ev;
    e = (len < MINL) ? MINL : len;
    total = HDR + e;
    k = 0;
    while (k < total) begin
      ev = {1'b1, 1'(k == total - 1), 1'(k < HDR), 1'(k >= HDR && k < HDR + len),
            1'(k >= HDR + len), 16'(k)};
      check_eq("beat", 64'({tvalid, tlast, hdr_phase, data_phase, pad_phase, byte_idx}),
               64'(ev));
      if (k == abort_at) begin
        rst = 1'b1;
        req = '0;
        tick();
        check_eq("mid_reset", idle_vec(), 64'(0));
        rst = 1'b0;
        m_rr = 0;
        tick();
        check_eq("post_reset_idle", idle_vec(), 64'(0));
        return;
      end
      tr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tready = tr;
      req = 2'($urandom);
      req_len = $urandom;
      tick();
      if (tr) k++;
    end
    check_eq("frame_done", 64'({frame_done, tvalid, tlast, busy, byte_idx, hdr_phase, data_phase,
                                pad_phase}), 64'({1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 3'b000}));
    tready = 1'b1;
    for (int j = 1; j <= IFG; j++) begin
      tick();
      check_eq("gap", 64'({busy, tvalid, grant, frame_done}), 64'({1'(j < IFG), 1'b0, 2'b00, 1'b0}));
    end
  endtask

  task automatic serve(input logic [1:0] r, input logic [15:0] l0, input logic [15:0] l1,
                       input bit bp, input int abort_at);
    try_arb(r, l0, l1);
    if (won != 0) run_frame(cur_len, bp, abort_at);
  endtask

  function automatic logic [15:0] rand_len();
    case ($urandom_range(0, 7))
      0: return 16'd0;
      1: return 16'(1501 + $urandom_range(0, 99));
      2: return 16'd1;
      3: return 16'(45 + $urandom_range(0, 2));
      4: return 16'hffff;
      default: return 16'($urandom_range(1, 200));
    endcase
  endfunction

  initial begin
    int zl[3];
    int z_rr;
    int z_cur;
    int z_frames;
    int z_cnt;
    bit prev_fd;
    zl = '{5, 3, 6};

    repeat (3) tick();
    check_eq("reset_state", idle_vec(), 64'(0));
    check_eq("reset_state_z", 64'({z_grant, z_busy, z_tvalid, z_idx}), 64'(0));
    rst = 1'b0;
    tick();

    serve(2'b01, 16'd100, 16'd0, 1'b0, -1);
    serve(2'b01, 16'd10, 16'd0, 1'b0, -1);
    serve(2'b10, 16'd0, 16'd46, 1'b1, -1);
    repeat (4) serve(2'b11, 16'd46, 16'd46, 1'b0, -1);

    serve(2'b01, 16'd0, 16'd0, 1'b0, -1);
    serve(2'b10, 16'd0, 16'd1501, 1'b0, -1);
    serve(2'b11, 16'd1501, 16'd0, 1'b0, -1);
    serve(2'b11, 16'd20, 16'd47, 1'b0, -1);
    serve(2'b10, 16'd0, 16'd1500, 1'b0, -1);
    serve(2'b01, 16'd1, 16'd0, 1'b1, -1);

    repeat (14) serve(2'($urandom), rand_len(), rand_len(), 1'($urandom_range(0, 1)), -1);

    serve(2'b11, 16'd200, 16'd200, 1'b0, 30);
    serve(2'b11, 16'd50, 16'd50, 1'b0, -1);
    req = '0;

    // Zero-gap instance: each grant must land the cycle right after frame_done.
    z_req = 3'b111;
    z_rr = 0;
    z_cur = 0;
    z_frames = 0;
    z_cnt = 0;
    prev_fd = 1'b1;
    for (int c = 0; c < 300 && z_frames < 6; c++) begin
      tick();
      if (prev_fd) begin
        check_eq("ifg0_grant", 64'({z_grant, z_id}), 64'({3'(1 << z_rr), 2'(z_rr)}));
        z_cur = z_rr;
        z_rr = (z_rr + 1) % 3;
        z_cnt = 0;
      end
      if (z_tvalid) z_cnt++;
      if (z_done) begin
        check_eq("ifg0_beats", 64'(z_cnt), 64'(2 + ((zl[z_cur] < 4) ? 4 : zl[z_cur])));
        z_frames++;
      end
      prev_fd = z_done;
    end
    check_eq("ifg0_frames", 64'(z_frames), 64'(6));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_frame_sched.md
# tx_frame_sched

Frame-level controller for the transmit pattern generator. Arbitrates round-robin between NUM_REQ frame requesters, latches the winner's payload length, and sequences one Ethernet frame as an AXI-Stream beat sequence: header beats, payload beats, and minimum-length padding. It drives tvalid, tlast and beat-position flags to the byte-mux datapath, then enforces an inter-frame gap before the next grant.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- HDR_LEN, 14: header beats per frame (DA, SA and EtherType).
- MIN_LEN, 46: minimum payload beats; shorter payloads are padded up to this.
- MAX_LEN, 1500: maximum legal payload length.
- IFG_CYCLES, 12: idle cycles after each frame. 0 is legal.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester frame request, level.
- req_len  in  NUM_REQ×16  per-requester payload length. Sampled only at grant.
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted or rejected.
- active_id  out  $clog2(NUM_REQ)  index of the requester owning the current frame.
- busy  out  1  high in HDR, DATA and GAP.
- tvalid  out  1  AXI-Stream valid.
- tready  in  1  AXI-Stream ready from the MAC.
- tlast  out  1  high on the final beat of the frame.
- byte_idx  out  16  beat index within the frame, starting at 0.
- hdr_phase  out  1  high while byte_idx < HDR_LEN.
- data_phase  out  1  high while byte_idx ≥ HDR_LEN and the beat is real payload.
- pad_phase  out  1  high on padding beats.
- frame_done  out  1  one-cycle pulse after the tlast beat is accepted.
- len_err  out  1  one-cycle pulse, coincident with grant, when a request is rejected.

## Operation
- States: IDLE, HDR, DATA, GAP.
- **IDLE, arbitration.**
  - Round-robin search starts at index rr_ptr and wraps around.
  - rr_ptr becomes winner+1 modulo NUM_REQ after every grant, including rejections.
- **Rejection.** A winner with req_len == 0 or req_len > MAX_LEN is rejected:
  - grant and len_err pulse;
  - no frame is sent;
  - the state stays IDLE.
- **Acceptance.** Otherwise:
  - grant pulses;
  - L = req_len and E = max(L, MIN_LEN) are latched;
  - active_id is latched;
  - the state goes to HDR.
- **Frame length.** The frame has HDR_LEN+E beats, with byte_idx running 0..HDR_LEN+E−1.
- **Beat acceptance.** byte_idx advances only on tvalid & tready.
- **Hold rule.** With tready low, all outputs hold stable.
- **HDR to DATA.** The state moves HDR→DATA when the beat with byte_idx == HDR_LEN−1 is accepted.
- **Beat flags.**
  - data_phase = byte_idx < HDR_LEN+L.
  - pad_phase = byte_idx ≥ HDR_LEN+L.
  - hdr_phase, data_phase and pad_phase are mutually exclusive and all low outside HDR/DATA.
- **tlast.** tlast = (byte_idx == HDR_LEN+E−1) while in DATA.
- **End of frame.**
  - When the tlast beat is accepted, the next cycle has frame_done = 1, byte_idx = 0 and state GAP.
  - If IFG_CYCLES == 0, the next state is IDLE directly instead of GAP.
- **GAP.** tvalid stays low for exactly IFG_CYCLES cycles, then the state returns to IDLE.
- **Input changes.**
  - req deasserting or req_len changing mid-frame has no effect.
  - A new req raised during the frame is served only after GAP.
- **Arithmetic.** All arithmetic is 16-bit unsigned. HDR_LEN+MAX_LEN < 65536 (elaboration assert).

## Timing
- All outputs are registered.
- **Reset values.**
  - Outputs: grant = 0, active_id = 0, busy = 0, tvalid = 0, tlast = 0, byte_idx = 0, all phase flags 0, frame_done = 0, len_err = 0.
  - Internal: state IDLE, rr_ptr = 0.
- **Request latency.** req sampled high in IDLE at edge n gives grant, tvalid = 1, hdr_phase = 1 and byte_idx = 0 in cycle n+1.
- **Minimum frame duration.** With tready held high, a frame occupies HDR_LEN+E cycles.
- **Back-to-back spacing.** Next-frame grant comes no earlier than IFG_CYCLES+1 cycles after frame_done.
- **Rejection spacing.** A rejection occupies one IDLE cycle, and the next arbitration occurs the following cycle.
- **Reset mid-frame.** rst high on any edge returns everything to reset values the next cycle. tvalid drops immediately, and no frame_done is issued.
- **Simultaneous requests.** The winner is decided by rr_ptr only.

## Test plan
- **Single legal frame.** Reset, then req[0] with req_len = 100, tready = 1. Expect:
  - grant = 01 one cycle later;
  - 114 tvalid beats;
  - hdr_phase on beats 0..13;
  - tlast only on byte_idx = 113;
  - frame_done the next cycle;
  - 12 idle cycles.
- **Short payload padding.** req_len = 10. Expect:
  - 60 beats;
  - data_phase on byte_idx 14..23;
  - pad_phase on byte_idx 24..59;
  - tlast at 59.
- **Backpressure.** Toggle tready pseudo-randomly during a 46-byte frame. Expect:
  - byte_idx, tlast and the phase flags hold while tready = 0;
  - exactly 60 accepted beats.
- **Round-robin fairness.** With NUM_REQ = 2, hold req = 11 continuously with lengths 46/46. Expect:
  - grants alternating 01, 10, 01, ...;
  - active_id matching each grant;
  - IFG respected between frames.
- **Length errors.** req_len = 0, then req_len = 1501. Expect:
  - grant and len_err pulses;
  - tvalid stays 0;
  - rr_ptr advances;
  - a subsequent legal request is served on the next cycle.
- **Reset mid-frame and IFG_CYCLES = 0.**
  - Assert rst at byte_idx = 30: tvalid = 0 and state IDLE next cycle, and req[0] wins the next arbitration.
  - With IFG_CYCLES = 0 and continuous requests: grant follows frame_done by one cycle.
